// File: rtl/if_fetch_stage.sv
// Instruction fetch: owns the PC, one outstanding imem read, single-entry slot.
// Define FETCH_CNT_EN to add the fetch_count / drop_count outputs.
module if_fetch_stage #(
   parameter int                   DATA_SIZE = 32,
   parameter int                   ADDR_SIZE = 10,
   parameter logic [ADDR_SIZE-1:0] RESET_PC  = '0
) (
   input  logic                 clk,
   input  logic                 clear,
   input  logic                 stall_id,
   input  logic                 redirect_en,
   input  logic [ADDR_SIZE-1:0] redirect_pc,
   output logic                 imem_req,
   output logic [ADDR_SIZE-1:0] imem_addr,
   input  logic                 imem_rvalid,
   input  logic [DATA_SIZE-1:0] imem_rdata,
   output logic [ADDR_SIZE-1:0] pc_if,
   output logic [DATA_SIZE-1:0] inst_if,
   output logic                 valid_if
`ifdef FETCH_CNT_EN
  ,output logic [31:0]          fetch_count,
   output logic [31:0]          drop_count
`endif
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_DROP
   } state_t;

   localparam logic [ADDR_SIZE-1:0] PC_STEP = ADDR_SIZE'(4);
   localparam logic [ADDR_SIZE-1:0] AL_MASK = ~ADDR_SIZE'(3);

   state_t               state;
   state_t               state_nx;
   logic [ADDR_SIZE-1:0] pc;
   logic [ADDR_SIZE-1:0] pc_nx;
   logic [ADDR_SIZE-1:0] redirect_al;
   logic                 consume;
   logic                 fill;
   logic                 drop;

   assign redirect_al = redirect_pc & AL_MASK;
   assign consume     = valid_if && !stall_id;
   assign imem_addr   = pc;

   always_comb begin
      state_nx = state;
      pc_nx    = pc;
      imem_req = 1'b0;
      fill     = 1'b0;
      drop     = 1'b0;
      unique case (state)
         S_IDLE: begin
            if (!redirect_en && (!valid_if || consume)) begin
               imem_req = 1'b1;
               state_nx = S_WAIT;
            end
         end
         S_WAIT: begin
            if (imem_rvalid) begin
               state_nx = S_IDLE;
               if (redirect_en) begin
                  drop = 1'b1;
               end else begin
                  fill  = 1'b1;
                  pc_nx = pc + PC_STEP;
               end
            end else if (redirect_en) begin
               state_nx = S_DROP;
            end
         end
         S_DROP: begin
            if (imem_rvalid) begin
               drop     = 1'b1;
               state_nx = S_IDLE;
            end
         end
         default: state_nx = S_IDLE;
      endcase
      if (redirect_en) pc_nx = redirect_al;
      // clear wins over everything, including the combinational request
      if (clear) imem_req = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (clear) begin
         state    <= S_IDLE;
         pc       <= RESET_PC;
         pc_if    <= '0;
         inst_if  <= '0;
         valid_if <= 1'b0;
      end else begin
         state <= state_nx;
         pc    <= pc_nx;
         if (fill) begin
            pc_if    <= pc;
            inst_if  <= imem_rdata;
            valid_if <= 1'b1;
         end else if (redirect_en || consume) begin
            valid_if <= 1'b0;
         end
      end
   end

`ifdef FETCH_CNT_EN
   always_ff @(posedge clk) begin
      if (clear) begin
         fetch_count <= '0;
         drop_count  <= '0;
      end else begin
         if (fill) fetch_count <= fetch_count + 32'd1;
         if (drop) drop_count  <= drop_count + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage with a small variable-latency imem model.
// Counter checks are included when FETCH_CNT_EN is defined.
module tb_if_fetch_stage;

   logic        clk = 1'b0;
   logic        clear = 1'b1;
   logic        stall_id = 1'b0;
   logic        redirect_en = 1'b0;
   logic [9:0]  redirect_pc = '0;
   logic        imem_req;
   logic [9:0]  imem_addr;
   logic        imem_rvalid = 1'b0;
   logic [31:0] imem_rdata = '0;
   logic [9:0]  pc_if;
   logic [31:0] inst_if;
   logic        valid_if;
`ifdef FETCH_CNT_EN
   logic [31:0] fetch_count;
   logic [31:0] drop_count;
`endif

   int         lat = 1;
   int         cnt = 0;
   logic [9:0] paddr = '0;
   int         npass = 0;
   int         ntot = 0;

   always #5 clk = ~clk;

   if_fetch_stage #(
      .DATA_SIZE(32),
      .ADDR_SIZE(10),
      .RESET_PC(10'd0)
   ) dut (
      .clk(clk),
      .clear(clear),
      .stall_id(stall_id),
      .redirect_en(redirect_en),
      .redirect_pc(redirect_pc),
      .imem_req(imem_req),
      .imem_addr(imem_addr),
      .imem_rvalid(imem_rvalid),
      .imem_rdata(imem_rdata),
      .pc_if(pc_if),
      .inst_if(inst_if),
      .valid_if(valid_if)
`ifdef FETCH_CNT_EN
     ,.fetch_count(fetch_count),
      .drop_count(drop_count)
`endif
   );

   function automatic logic [31:0] mk(input logic [9:0] a);
      return 32'hC0DE_0000 | {22'd0, a};
   endfunction

   always @(posedge clk) begin
      imem_rvalid <= 1'b0;
      if (cnt == 1) begin
         imem_rvalid <= 1'b1;
         imem_rdata  <= mk(paddr);
      end
      if (cnt != 0) cnt <= cnt - 1;
      if (imem_req) begin
         if (lat == 1) begin
            imem_rvalid <= 1'b1;
            imem_rdata  <= mk(imem_addr);
         end else begin
            cnt   <= lat - 1;
            paddr <= imem_addr;
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      ntot++;
      assert (got === exp) npass++;
      else $error("FAIL %s: got %h, expected %h", tag, got, exp);
   endtask

   initial begin
      repeat (2) @(negedge clk);
      #1;
      chk("rst_req", 32'(imem_req), 32'd0);
      chk("rst_addr", 32'(imem_addr), 32'd0);
      chk("rst_valid", 32'(valid_if), 32'd0);
      chk("rst_pc_if", 32'(pc_if), 32'd0);
      chk("rst_inst", inst_if, 32'd0);

      @(negedge clk); clear = 1'b0; #1;
      chk("c1_req", 32'(imem_req), 32'd1);
      chk("c1_addr", 32'(imem_addr), 32'd0);

      @(negedge clk); #1;
      chk("c2_req", 32'(imem_req), 32'd0);
      chk("c2_valid", 32'(valid_if), 32'd0);

      @(negedge clk); #1;
      chk("c3_valid", 32'(valid_if), 32'd1);
      chk("c3_pc_if", 32'(pc_if), 32'h000);
      chk("c3_inst", inst_if, mk(10'h000));
      chk("c3_req", 32'(imem_req), 32'd1);
      chk("c3_addr", 32'(imem_addr), 32'h004);

      @(negedge clk); #1;
      chk("c4_valid", 32'(valid_if), 32'd0);

      @(negedge clk); #1;
      chk("c5_valid", 32'(valid_if), 32'd1);
      chk("c5_pc_if", 32'(pc_if), 32'h004);
      chk("c5_inst", inst_if, mk(10'h004));
      chk("c5_addr", 32'(imem_addr), 32'h008);
      chk("c5_req", 32'(imem_req), 32'd1);

      @(negedge clk); stall_id = 1'b1; #1;
      chk("c6_req", 32'(imem_req), 32'd0);

      for (int i = 0; i < 5; i++) begin
         @(negedge clk); #1;
         chk("stall_valid", 32'(valid_if), 32'd1);
         chk("stall_pc_if", 32'(pc_if), 32'h008);
         chk("stall_inst", inst_if, mk(10'h008));
         chk("stall_req", 32'(imem_req), 32'd0);
      end

      @(negedge clk); stall_id = 1'b0; lat = 4; #1;
      chk("unstall_req", 32'(imem_req), 32'd1);
      chk("unstall_addr", 32'(imem_addr), 32'h00C);

      @(negedge clk); redirect_en = 1'b1; redirect_pc = 10'h107; #1;
      chk("rd_wait_req", 32'(imem_req), 32'd0);

      @(negedge clk); redirect_en = 1'b0; redirect_pc = '0; #1;
      chk("drop_addr", 32'(imem_addr), 32'h104);
      chk("drop_req0", 32'(imem_req), 32'd0);
      chk("drop_valid0", 32'(valid_if), 32'd0);

      @(negedge clk); #1;
      chk("drop_req1", 32'(imem_req), 32'd0);

      @(negedge clk); #1;
      chk("drop_req2", 32'(imem_req), 32'd0);
      chk("drop_valid2", 32'(valid_if), 32'd0);

      @(negedge clk); lat = 1; #1;
      chk("post_drop_req", 32'(imem_req), 32'd1);
      chk("post_drop_addr", 32'(imem_addr), 32'h104);
      chk("post_drop_valid", 32'(valid_if), 32'd0);
      chk("post_drop_inst", inst_if, mk(10'h008));
`ifdef FETCH_CNT_EN
      chk("cnt_drop1", drop_count, 32'd1);
      chk("cnt_fetch3", fetch_count, 32'd3);
`endif

      @(negedge clk); #1;
      chk("c18_req", 32'(imem_req), 32'd0);

      @(negedge clk); #1;
      chk("c19_valid", 32'(valid_if), 32'd1);
      chk("c19_pc_if", 32'(pc_if), 32'h104);
      chk("c19_inst", inst_if, mk(10'h104));
      chk("c19_addr", 32'(imem_addr), 32'h108);

      @(negedge clk);
      redirect_en = 1'b1; redirect_pc = 10'h3FC; stall_id = 1'b1; #1;
      chk("rd_rv_req", 32'(imem_req), 32'd0);

      @(negedge clk); redirect_en = 1'b0; stall_id = 1'b0; #1;
      chk("rd_rv_valid", 32'(valid_if), 32'd0);
      chk("rd_rv_pc_if", 32'(pc_if), 32'h104);
      chk("rd_rv_inst", inst_if, mk(10'h104));
      chk("rd_rv_req1", 32'(imem_req), 32'd1);
      chk("rd_rv_addr", 32'(imem_addr), 32'h3FC);
`ifdef FETCH_CNT_EN
      chk("cnt_drop2", drop_count, 32'd2);
`endif

      @(negedge clk); #1;
      @(negedge clk); #1;
      chk("wrap_valid", 32'(valid_if), 32'd1);
      chk("wrap_pc_if", 32'(pc_if), 32'h3FC);
      chk("wrap_addr", 32'(imem_addr), 32'h000);
      chk("wrap_req", 32'(imem_req), 32'd1);

      @(negedge clk); #1;
      @(negedge clk); lat = 2; #1;
      chk("c25_pc_if", 32'(pc_if), 32'h000);
      chk("c25_addr", 32'(imem_addr), 32'h004);
`ifdef FETCH_CNT_EN
      chk("cnt_fetch6", fetch_count, 32'd6);
`endif

      @(negedge clk); clear = 1'b1; #1;
      chk("clr_req", 32'(imem_req), 32'd0);

      @(negedge clk); clear = 1'b0; lat = 1; #1;
      chk("clr_valid", 32'(valid_if), 32'd0);
      chk("clr_pc_if", 32'(pc_if), 32'd0);
      chk("clr_inst", inst_if, 32'd0);
      chk("clr_req1", 32'(imem_req), 32'd1);
      chk("clr_addr", 32'(imem_addr), 32'd0);
`ifdef FETCH_CNT_EN
      chk("clr_fetch", fetch_count, 32'd0);
      chk("clr_drop", drop_count, 32'd0);
`endif

      @(negedge clk); #1;
      chk("clr_ignored", 32'(valid_if), 32'd0);

      @(negedge clk); #1;
      chk("clr_refetch_v", 32'(valid_if), 32'd1);
      chk("clr_refetch_pc", 32'(pc_if), 32'd0);
      chk("clr_refetch_i", inst_if, mk(10'h000));

      $display("%0d/%0d checks passed", npass, ntot);
      $finish;
   end

endmodule

// File: doc/if_fetch_stage.md
# if_fetch_stage

Instruction-fetch stage of the pipelined core. Owns the program counter, issues one instruction-memory read at a time, and presents each fetched instruction with its PC to the IF/ID pipeline register through a single-entry output slot. It honours back-pressure from decode (`stall_id`) and squashes the output slot and any in-flight fetch on a redirect from a branch or jump.

## Interface
- `DATA_SIZE`, 32: instruction width.
- `ADDR_SIZE`, 10: PC / byte-address width.
- `RESET_PC`, 0: PC loaded on `clear`; must be a multiple of 4.

- `clk`  in  1  clock; all state updates on the rising edge.
- `clear`  in  1  reset, synchronous and active-high.
- `stall_id`  in  1  decode is holding; output slot must not advance.
- `redirect_en`  in  1  single-cycle branch/jump redirect request.
- `redirect_pc`  in  ADDR_SIZE  redirect target; bits [1:0] ignored, forced to 0.
- `imem_req`  out  1  read request, valid for one cycle.
- `imem_addr`  out  ADDR_SIZE  read address; equals the internal PC.
- `imem_rvalid`  in  1  read data valid; latency ≥1 cycle after `imem_req`.
- `imem_rdata`  in  DATA_SIZE  read data.
- `pc_if`  out  ADDR_SIZE  PC of the slot instruction.
- `inst_if`  out  DATA_SIZE  slot instruction.
- `valid_if`  out  1  slot holds a valid instruction.

## Operation
- State: `pc` register, output slot (`pc_if`, `inst_if`, `valid_if`), and a 3-state FSM: IDLE, WAIT, DROP.
- Reset: `pc`=RESET_PC, FSM=IDLE, `pc_if`=0, `inst_if`=0, `valid_if`=0. `imem_req`=0 while `clear`=1.
- Slot consumption: the slot is consumed in any cycle where `valid_if`=1 and `stall_id`=0.
- IDLE: `imem_req`=1 when `redirect_en`=0 and either `valid_if`=0 or the slot is consumed this cycle. On a request, go to WAIT; otherwise stay in IDLE.
- WAIT: `imem_req`=0. When `imem_rvalid`=1 and `redirect_en`=0:
  - slot <= {`pc`, `imem_rdata`, 1};
  - `pc` <= `pc`+4;
  - go to IDLE.
- WAIT and the slot: only one request is outstanding, and a request is issued only when the slot is free, so a response always finds the slot empty.
- DROP: wait for the response of a squashed request. When `imem_rvalid`=1, discard the data and go to IDLE.
- Slot clearing: a consumed slot that is not refilled in the same cycle goes to `valid_if`=0; `pc_if` and `inst_if` keep their stale values.
- Redirect (`redirect_en`=1) takes priority over `stall_id` and over fetch:
  - `pc` <= {`redirect_pc`[ADDR_SIZE-1:2], 2'b00};
  - `valid_if` <= 0;
  - no request is issued that cycle.
- Redirect FSM next state:
  - IDLE -> IDLE.
  - WAIT with `imem_rvalid`=1 -> IDLE (response discarded).
  - WAIT with `imem_rvalid`=0 -> DROP.
  - DROP -> IDLE if `imem_rvalid`=1, else DROP.
- Arithmetic: `pc`+4 wraps modulo 2^ADDR_SIZE (1020 -> 0 with the defaults).
- `clear` overrides every other input in the same cycle. A response arriving in the cycle after a mid-fetch `clear` is ignored, because the FSM is in IDLE.

## Timing
- `imem_addr` = `pc` combinationally. `imem_req` is combinational from the FSM state, `valid_if`, `stall_id`, `redirect_en` and `clear`.
- Minimum fetch period is 2 cycles per instruction (IDLE request, WAIT response), reached with memory latency 1 and no stall.
- Response-to-`valid_if` latency is 1 cycle: the slot is registered on the `imem_rvalid` edge.
- Redirect-to-request latency:
  - 1 cycle from IDLE or WAIT.
  - From DROP, 1 cycle after the pending `imem_rvalid`.
- Slot outputs are stable while `stall_id`=1 and no redirect occurs.

## Configuration
- `FETCH_CNT_EN` defined adds two outputs:
  - `fetch_count` [31:0]: counts responses written to the slot.
  - `drop_count` [31:0]: counts responses discarded, whether in DROP or by a redirect coinciding with `imem_rvalid`.
- Both counters reset to 0 on `clear` and wrap at 2^32.
- Without `FETCH_CNT_EN`: these ports and counters do not exist; all other behaviour is identical.

## Test plan
- Reset then free-run, memory latency 1, `stall_id`=0 -> `imem_addr` 0, 4, 8 on cycles 1, 3, 5 after `clear` drops; `valid_if` pulses with `pc_if` 0, 4, 8 one cycle after each response.
- `stall_id`=1 for 5 cycles while `valid_if`=1 -> slot holds `pc_if`=8 and its `inst_if` unchanged; no `imem_req` until the cycle `stall_id` falls.
- Redirect to 0x104 in WAIT, response delayed 3 cycles -> FSM enters DROP; the late data never appears on `inst_if`; the next request has `imem_addr`=0x104.
- `redirect_en` coinciding with `imem_rvalid` and with `stall_id`=1 -> `valid_if`=0 next cycle; the next fetch is at the redirect PC. With `FETCH_CNT_EN`, `drop_count` increments by 1.
- PC at 1020 (`ADDR_SIZE`=10) -> the next fetch address is 0.
- `clear` asserted in WAIT, response arriving the next cycle -> outputs at reset values; the response is ignored; the first request has `imem_addr`=RESET_PC.
